// File: rtl/prog_loader_if.sv
// Instruction-memory write bus between the program loader and the CPU core.
// The loader drives it (master); the memory side only observes (slave).
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/prog_loader.sv
// Host pin-strobed program loader: assembles low/high byte pairs into 16-bit
// words, writes them into instruction memory, and holds the CPU while loading.
module prog_loader #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_en_in,
    input  logic                strb_in,
    input  logic [7:0]          data_in,
    prog_loader_if.master       imem,
    output logic                cpu_hold,
    output logic                busy,
    output logic [ADDR_W:0]     words_loaded,
    output logic                overflow
);
    typedef enum logic [2:0] {IDLE, WAIT_LO, WAIT_HI, WRITE, DONE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ld_sync_q, strb_sync_q;
    logic                   strb_q;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W:0]        words_q, words_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             lo_q, lo_d, hi_q, hi_d;

    logic load_en_s, strb_s, strb_rise, full;

    assign load_en_s = ld_sync_q[SYNC_STAGES-1];
    assign strb_s    = strb_sync_q[SYNC_STAGES-1];
    assign strb_rise = strb_s & ~strb_q;
    // Word counter reaching 2^ADDR_W coincides with the address wrapping to 0.
    assign full      = words_q[ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_sync_q   <= '0;
            strb_sync_q <= '0;
            strb_q      <= 1'b0;
            addr_q      <= '0;
            words_q     <= '0;
            ovf_q       <= 1'b0;
            lo_q        <= 8'h00;
            hi_q        <= 8'h00;
        end else begin
            state_q     <= state_d;
            ld_sync_q   <= {ld_sync_q[SYNC_STAGES-2:0], load_en_in};
            strb_sync_q <= {strb_sync_q[SYNC_STAGES-2:0], strb_in};
            strb_q      <= strb_s;
            addr_q      <= addr_d;
            words_q     <= words_d;
            ovf_q       <= ovf_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        ovf_d   = ovf_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE: begin
                if (load_en_s) begin
                    state_d = WAIT_LO;
                    addr_d  = '0;
                    words_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            WAIT_LO: begin
                // A strobe is honoured before a coincident session end.
                if (strb_rise) begin
                    if (!full) begin
                        lo_d    = data_in;
                        state_d = WAIT_HI;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (!load_en_s) begin
                    state_d = DONE;
                end
            end
            WAIT_HI: begin
                if (strb_rise) begin
                    hi_d    = data_in;
                    state_d = WRITE;
                end else if (!load_en_s) begin
                    hi_d    = 8'h00;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + 1'b1;
                words_d = words_q + 1'b1;
                state_d = load_en_s ? WAIT_LO : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign imem.imem_we    = (state_q == WRITE);
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = {hi_q, lo_q};
    assign busy            = (state_q != IDLE);
    assign cpu_hold        = busy;
    assign words_loaded    = words_q;
    assign overflow        = ovf_q;
endmodule
